// File: rtl/j_i2s_tx.sv
// rtl/j_i2s_tx.sv - I2S-style serial audio transmitter with internal bit-clock divider
// Left/right holding registers are serialised MSB first, WS leading data by one bit.
module j_i2s_tx #(
  parameter int WIDTH = 16,
  parameter int DIV_W = 8
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             enable,
  input  logic [DIV_W-1:0] sclk_div,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_l,
  input  logic             wr_r,
  output logic             sck,
  output logic             ws,
  output logic             sdata,
  output logic             req,
  output logic             busy
);
  localparam int BW = $clog2(2*WIDTH);
  localparam logic [BW-1:0] LAST = BW'(2*WIDTH-1);
  localparam logic [BW-1:0] HALF = BW'(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0] left_h, right_h, shift;
  logic [DIV_W-1:0] div_cnt;
  logic [BW-1:0]    bitcnt, b, b_next;
  logic             tick, fall, active;

  always_ff @(posedge sys_clk) begin
    if (!resetl) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      IDLE: if (enable) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (!enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign active = (state == RUN) && enable;
  // >= rather than == so a lowered divider mid-count still ticks at once
  assign tick   = div_cnt >= sclk_div;
  assign fall   = tick && sck;
  assign b      = (bitcnt == LAST) ? '0 : bitcnt + BW'(1);
  assign b_next = (b == LAST) ? '0 : b + BW'(1);

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      left_h  <= '0;
      right_h <= '0;
    end else begin
      if (wr_l) left_h  <= din;
      if (wr_r) right_h <= din;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl || !active) begin
      sck     <= 1'b0;
      ws      <= 1'b0;
      sdata   <= 1'b0;
      req     <= 1'b0;
      shift   <= '0;
      div_cnt <= '0;
      bitcnt  <= LAST;
    end else begin
      req <= 1'b0;
      if (tick) begin
        div_cnt <= '0;
        sck     <= ~sck;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
      if (fall) begin
        bitcnt <= b;
        ws     <= (b_next >= HALF);
        if (b == '0) begin
          shift <= left_h << 1;
          sdata <= left_h[WIDTH-1];
          req   <= 1'b1;
        end else if (b == HALF) begin
          shift <= right_h << 1;
          sdata <= right_h[WIDTH-1];
        end else begin
          sdata <= shift[WIDTH-1];
          shift <= shift << 1;
        end
      end
    end
  end

endmodule
